// File: rtl/alu_seq.sv
// Purpose : multi-byte add/subtract, one 8-bit slice per clock, LSB first, carry chained between slices.
// Latency : start sampled at E0, result/flags load at E(NBYTES), done high for the following cycle.
// Backpr. : none; start is accepted only in IDLE or DONE and ignored while busy (no queueing).
module alu_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic                  overflow
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          c;
    logic          zacc;
    logic          op_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  work;

    logic [7:0]    a_byte;
    logic [7:0]    bx_byte;
    logic [8:0]    sum9;
    logic [7:0]    s;
    logic          co;
    logic          s_zero;
    logic [W-1:0]  byte_mask;
    logic [W-1:0]  work_nxt;

    // Handshake outputs are plain decodes of the state register, so start never reaches them combinationally.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Current byte slice: select byte idx, invert B for subtract, add with chained carry.
    always_comb begin
        a_byte    = 8'(a_r >> {idx, 3'b000});
        bx_byte   = 8'(b_r >> {idx, 3'b000}) ^ {8{op_r}};
        sum9      = {1'b0, a_byte} + {1'b0, bx_byte} + {8'd0, c};
        s         = sum9[7:0];
        co        = sum9[8];
        s_zero    = (s == 8'd0);
        byte_mask = W'(8'hFF) << {idx, 3'b000};
        work_nxt  = (work & ~byte_mask) | (W'(s) << {idx, 3'b000});
    end

    // Sequencer: latch operands on start, walk the slices, publish result and flags on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            c        <= 1'b0;
            zacc     <= 1'b0;
            op_r     <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            work     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                        c     <= op;
                        idx   <= '0;
                        zacc  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work <= work_nxt;
                    c    <= co;
                    zacc <= zacc & s_zero;
                    if (idx == LAST) begin
                        state    <= DONE;
                        result   <= work_nxt;
                        carry    <= co;
                        zero     <= zacc & s_zero;
                        // On the top slice a_byte/bx_byte/s hold the sign bits of A, op-adjusted B and the result.
                        overflow <= (a_byte[7] == bx_byte[7]) && (s[7] != a_byte[7]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
